instr_fetch_unit: RTL and testbench

- IF stage of the MIPS 5-stage pipeline; the initiator side of the instruction-memory read interface.
- Owns the PC register and drives the word address to the instruction ROM, which returns the instruction combinationally in the same cycle.
- Captures the instruction into the IF/ID pipeline register and handles stall, flush and branch/jump redirect from later stages.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/pc_reg.sv | 38 +++
 rtl/instr_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared widths, IF/ID payload type and fetch FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int PC_WIDTH    = 32;
    localparam int INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]    pc_next;
        logic                   valid;
    } if_id_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program counter with next-PC mux: redirect > hold > increment.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] PC_RESET = '0,
    parameter int                  PC_STEP  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    input  logic                hold,
    output logic [PC_WIDTH-1:0] pc_q,
    output logic [PC_WIDTH-1:0] pc_seq
);

    logic [PC_WIDTH-1:0] r_pc;

    // Sequential successor wraps naturally at 2^PC_WIDTH.
    assign pc_seq = r_pc + PC_WIDTH'(PC_STEP);
    assign pc_q   = r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= PC_RESET;
        end else if (redirect_valid) begin
            r_pc <= redirect_target;
        end else if (!hold) begin
            r_pc <= pc_seq;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : MIPS IF stage: PC, ROM address, IF/ID register, fetch counter.
//               Optional ROM bound check/halt enabled by IF_BOUND_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int                  PC_WIDTH    = mips_pkg::PC_WIDTH,
    parameter int                  INSTR_WIDTH = mips_pkg::INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0] PC_RESET    = '0,
    parameter int                  PC_STEP     = 1,
    parameter int                  IMEM_DEPTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    imem_pc,
    input  logic [INSTR_WIDTH-1:0] imem_instr,
    input  logic                   stall_if,
    input  logic                   flush_if,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_target,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0]    if_id_pc_next,
    output logic                   if_id_valid,
    output logic [15:0]            fetch_count
`ifdef IF_BOUND_CHECK_EN
    ,
    output logic                   fetch_halted
`endif
);

    import mips_pkg::*;

`ifdef IF_BOUND_CHECK_EN
    localparam bit c_bound_check = 1'b1;
`else
    localparam bit c_bound_check = 1'b0;
`endif

    fetch_state_t        r_state;
    fetch_state_t        w_state_next;
    if_id_t              r_if_id;
    logic [15:0]         r_fetch_count;
    logic [PC_WIDTH-1:0] w_pc;
    logic [PC_WIDTH-1:0] w_pc_seq;
    logic                w_beyond;
    logic                w_pc_redirect;
    logic                w_pc_hold;
    logic                w_ifid_bubble;
    logic                w_ifid_load;

    pc_reg #(
        .PC_WIDTH (PC_WIDTH),
        .PC_RESET (PC_RESET),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (w_pc_redirect),
        .redirect_target (redirect_target),
        .hold            (w_pc_hold),
        .pc_q            (w_pc),
        .pc_seq          (w_pc_seq)
    );

    // Constant-false in the default build, so the compare folds away.
    assign w_beyond = c_bound_check && (w_pc_seq >= PC_WIDTH'(IMEM_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BOOT: w_state_next = RUN;
            RUN: begin
                if (w_beyond && !redirect_valid) begin
                    w_state_next = HALT;
                end
            end
`ifdef IF_BOUND_CHECK_EN
            HALT: begin
                if (w_pc_redirect) begin
                    w_state_next = RUN;
                end
            end
`endif
            default: w_state_next = BOOT;
        endcase
    end

    // Defaults describe a frozen stage: PC held, bubble into IF/ID.
    always_comb begin
        w_pc_redirect = 1'b0;
        w_pc_hold     = 1'b1;
        w_ifid_bubble = 1'b1;
        w_ifid_load   = 1'b0;
        case (r_state)
            RUN: begin
                w_pc_redirect = redirect_valid;
                if (!(w_beyond && !redirect_valid)) begin
                    w_pc_hold     = stall_if;
                    w_ifid_bubble = flush_if || redirect_valid;
                    w_ifid_load   = !(flush_if || redirect_valid) && !stall_if;
                end
            end
`ifdef IF_BOUND_CHECK_EN
            HALT: begin
                w_pc_redirect = redirect_valid &&
                                (redirect_target < PC_WIDTH'(IMEM_DEPTH));
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_id <= '0;
        end else if (w_ifid_bubble) begin
            r_if_id <= '{instr: NOP_INSTR, pc_next: '0, valid: 1'b0};
        end else if (w_ifid_load) begin
            r_if_id <= '{instr: imem_instr, pc_next: w_pc_seq, valid: 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= '0;
        end else if (w_ifid_load && (r_fetch_count != 16'hFFFF)) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign imem_pc       = w_pc;
    assign if_id_instr   = r_if_id.instr;
    assign if_id_pc_next = r_if_id.pc_next;
    assign if_id_valid   = r_if_id.valid;
    assign fetch_count   = r_fetch_count;

`ifdef IF_BOUND_CHECK_EN
    assign fetch_halted = (r_state == HALT);
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed + randomized bench for instr_fetch_unit against a
//               cycle-level behavioural model of the IF stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        stall_if = 1'b0;
    logic        flush_if = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_next;
    logic        if_id_valid;
    logic [15:0] fetch_count;
`ifdef IF_BOUND_CHECK_EN
    logic        fetch_halted;
`endif

    logic [31:0] rom [32];

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcn;
    bit          m_valid;
    bit          m_boot;
    bit          m_halted;
    int          m_cnt;

    instr_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_pc         (imem_pc),
        .imem_instr      (imem_instr),
        .stall_if        (stall_if),
        .flush_if        (flush_if),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_id_instr     (if_id_instr),
        .if_id_pc_next   (if_id_pc_next),
        .if_id_valid     (if_id_valid),
        .fetch_count     (fetch_count)
`ifdef IF_BOUND_CHECK_EN
        ,
        .fetch_halted    (fetch_halted)
`endif
    );

    always #5 clk = ~clk;

    assign imem_instr = (imem_pc < 32) ? rom[imem_pc[4:0]] : 32'h0;

    function automatic logic [31:0] rom_read(input logic [31:0] a);
        return (a < 32) ? rom[a[4:0]] : 32'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_bubble();
        m_instr = 32'h0;
        m_pcn   = 32'h0;
        m_valid = 1'b0;
    endtask

    // One clock of IF-stage behaviour, from the rules rather than the RTL.
    task automatic model_update();
        logic [31:0] seq;
        seq = m_pc + 32'd1;
        if (reset) begin
            m_pc = 32'h0; m_boot = 1'b1; m_halted = 1'b0; m_cnt = 0;
            set_bubble();
        end else if (m_boot) begin
            m_boot = 1'b0;
            set_bubble();
`ifdef IF_BOUND_CHECK_EN
        end else if (m_halted) begin
            if (redirect_valid && redirect_target < 32) begin
                m_pc = redirect_target;
                m_halted = 1'b0;
            end
            set_bubble();
        end else if (!redirect_valid && seq >= 32) begin
            m_halted = 1'b1;
            set_bubble();
`endif
        end else begin
            if (flush_if || redirect_valid) begin
                set_bubble();
            end else if (!stall_if) begin
                m_instr = rom_read(m_pc);
                m_pcn   = seq;
                m_valid = 1'b1;
                if (m_cnt < 16'hFFFF) m_cnt++;
            end
            if (redirect_valid)  m_pc = redirect_target;
            else if (!stall_if)  m_pc = seq;
        end
    endtask

    task automatic compare_model();
        check("imem_pc",       imem_pc,       m_pc);
        check("if_id_instr",   if_id_instr,   m_instr);
        check("if_id_pc_next", if_id_pc_next, m_pcn);
        check("if_id_valid",   {31'h0, if_id_valid}, {31'h0, m_valid});
        check("fetch_count",   {16'h0, fetch_count}, m_cnt[31:0]);
`ifdef IF_BOUND_CHECK_EN
        check("fetch_halted",  {31'h0, fetch_halted}, {31'h0, m_halted});
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_model();
    endtask

    task automatic clear_inputs();
        stall_if = 1'b0; flush_if = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = $urandom;
        rom[3]  = 32'h0;
        rom[20] = 32'h0;
        m_pc = 0; m_instr = 0; m_pcn = 0; m_valid = 0; m_boot = 1; m_halted = 0; m_cnt = 0;

        // Reset state
        step(); step();
        check("rst_pc",    imem_pc, 32'h0);
        check("rst_valid", {31'h0, if_id_valid}, 32'h0);
        check("rst_count", {16'h0, fetch_count}, 32'h0);

        // Release: BOOT bubble, then 1 instr/clk
        reset = 1'b0;
        step();
        check("boot_pc",    imem_pc, 32'h0);
        check("boot_valid", {31'h0, if_id_valid}, 32'h0);
        step();
        check("first_pc",    imem_pc, 32'd1);
        check("first_instr", if_id_instr, rom[0]);
        check("first_pcn",   if_id_pc_next, 32'd1);
        step(); step();
        check("seq_pc",    imem_pc, 32'd3);
        check("seq_count", {16'h0, fetch_count}, 32'd3);

        // Stall two cycles at pc=5
        for (int k = 0; k < 20 && m_pc != 5; k++) step();
        stall_if = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("stall_pc",    imem_pc, 32'd5);
            check("stall_instr", if_id_instr, rom[4]);
            check("stall_pcn",   if_id_pc_next, 32'd5);
        end
        stall_if = 1'b0;
        step();
        check("resume_pc",    imem_pc, 32'd6);
        check("resume_instr", if_id_instr, rom[5]);

        // Redirect to 7 from pc=4 with stall
        redirect_valid = 1'b1; redirect_target = 32'd4;
        step();
        redirect_target = 32'd7; stall_if = 1'b1;
        step();
        check("redir_pc",    imem_pc, 32'd7);
        check("redir_valid", {31'h0, if_id_valid}, 32'h0);
        clear_inputs();
        step();
        check("redir_instr", if_id_instr, rom[7]);
        check("redir_pcn",   if_id_pc_next, 32'd8);

        // Flush with stall at pc=10
        redirect_valid = 1'b1; redirect_target = 32'd9;
        step();
        clear_inputs();
        step();
        flush_if = 1'b1; stall_if = 1'b1;
        step();
        check("flush_pc",    imem_pc, 32'd10);
        check("flush_valid", {31'h0, if_id_valid}, 32'h0);
        check("flush_instr", if_id_instr, 32'h0);
        clear_inputs();

        // PC wrap
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
        step();
        check("wrap_pre", imem_pc, 32'hFFFF_FFFF);
        clear_inputs();
        step();
        check("wrap_pc", imem_pc, 32'h0);

        // Reset mid-stall
        stall_if = 1'b1;
        step();
        reset = 1'b1;
        step();
        check("mid_rst_pc",    imem_pc, 32'h0);
        check("mid_rst_valid", {31'h0, if_id_valid}, 32'h0);
        check("mid_rst_count", {16'h0, fetch_count}, 32'h0);
        check("mid_rst_instr", if_id_instr, 32'h0);
        check("mid_rst_pcn",   if_id_pc_next, 32'h0);
        reset = 1'b0; clear_inputs();
        step();

`ifdef IF_BOUND_CHECK_EN
        redirect_valid = 1'b1; redirect_target = 32'd28;
        step();
        clear_inputs();
        for (int k = 0; k < 20 && !m_halted; k++) step();
        check("halt_flag", {31'h0, fetch_halted}, 32'd1);
        check("halt_pc",   imem_pc, 32'd31);
        step();
        check("halt_bubble", {31'h0, if_id_valid}, 32'h0);
        check("halt_hold",   imem_pc, 32'd31);
        redirect_valid = 1'b1; redirect_target = 32'd3;
        step();
        check("unhalt_pc",   imem_pc, 32'd3);
        check("unhalt_flag", {31'h0, fetch_halted}, 32'h0);
        clear_inputs();
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset           = ($urandom_range(0, 99) == 0);
            stall_if        = ($urandom_range(0, 3) == 0);
            flush_if        = ($urandom_range(0, 9) == 0);
            redirect_valid  = ($urandom_range(0, 11) == 0);
            redirect_target = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
